// File: rtl/exe_stage_bju_pkg.sv
// Shared definitions for the execute-stage branch/jump unit.
//   - BJ_W and the BJ_* bit positions of the one-hot branch-type bus
//     (bj_info) and the matching ALU condition bus (bj_data).
//   - bju_state_e: states of the redirect/flush controller.
package exe_stage_bju_pkg;

    localparam int BJ_W    = 8;
    localparam int BJ_BEQ  = 0;
    localparam int BJ_BNE  = 1;
    localparam int BJ_BLT  = 2;
    localparam int BJ_BGE  = 3;
    localparam int BJ_BLTU = 4;
    localparam int BJ_BGEU = 5;
    localparam int BJ_JALR = 6;
    localparam int BJ_JAL  = 7;

    typedef enum logic [1:0] {
        BJU_IDLE   = 2'd0,
        BJU_HOLD   = 2'd1,
        BJU_SQUASH = 2'd2
    } bju_state_e;

endpackage

// File: rtl/exe_stage_bju_target.sv
// Combinational target/link generation for the branch/jump unit.
// Ports:
//   pc, imm, rs1 : instruction PC, sign-extended immediate, JALR base
//   is_jalr      : selects rs1-relative target (bit 0 cleared)
//   target       : branch/jump destination, wraps modulo 2^ADDR_W
//   link         : pc + 4, wraps modulo 2^ADDR_W
module exe_stage_bju_target #(
    parameter int ADDR_W = 64
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] imm,
    input  logic [ADDR_W-1:0] rs1,
    input  logic              is_jalr,
    output logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] link
);

    logic [ADDR_W-1:0] jalr_sum;
    logic [ADDR_W-1:0] pc_sum;

    assign jalr_sum = rs1 + imm;
    assign pc_sum   = pc + imm;
    // JALR clears bit 0 of the computed address; bit 1 is left alone so a
    // half-word aligned JALR target still raises the misalignment exception.
    assign target   = is_jalr ? (jalr_sum & ~ADDR_W'(1)) : pc_sum;
    assign link     = pc + ADDR_W'(4);

endmodule

// File: rtl/exe_stage_bju.sv
// Branch/jump resolution unit in the execute stage.
// Decides taken/not-taken from the one-hot branch type and ALU condition
// bits, issues a redirect to fetch under valid/ready, then holds a flush of
// the front-end pipeline registers for FLUSH_CYCLES cycles.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_valid/in_ready : instruction handshake (ready only while idle)
//   pc, imm, rs1      : operands for target and link computation
//   bj_info, bj_data  : one-hot branch type, per-type condition bits
//   redirect_*        : redirect request to IF (valid/ready, target PC)
//   flush             : squash IF/ID and ID/EXE registers
//   link_valid/data   : one-cycle pc+4 writeback for JAL/JALR
//   misalign_exc      : one-cycle pulse, taken target not 4-byte aligned
module exe_stage_bju
    import exe_stage_bju_pkg::*;
#(
    parameter int ADDR_W       = 64,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] imm,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [BJ_W-1:0]   bj_info,
    input  logic [BJ_W-1:0]   bj_data,
    output logic              redirect_valid,
    input  logic              redirect_ready,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              flush,
    output logic              link_valid,
    output logic [ADDR_W-1:0] link_data,
    output logic              misalign_exc
);

    bju_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;
    logic [ADDR_W-1:0] link_data_q, link_data_d;
    logic              link_valid_q, link_valid_d;
    logic              misalign_q, misalign_d;

    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] link;
    logic              taken;
    logic              is_jalr;
    logic              is_link;
    logic              misaligned;

    // Multi-hot bj_info is not expected, but the OR reduction still gives a
    // well-defined answer if it ever shows up.
    assign taken      = |(bj_info & bj_data);
    assign is_jalr    = bj_info[BJ_JALR];
    assign is_link    = bj_info[BJ_JAL] | bj_info[BJ_JALR];
    assign misaligned = taken & (target[1:0] != 2'b00);

    exe_stage_bju_target #(
        .ADDR_W (ADDR_W)
    ) u_target (
        .pc      (pc),
        .imm     (imm),
        .rs1     (rs1),
        .is_jalr (is_jalr),
        .target  (target),
        .link    (link)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        redirect_pc_d = redirect_pc_q;
        link_data_d   = link_data_q;
        link_valid_d  = 1'b0;
        misalign_d    = 1'b0;

        case (state_q)
            BJU_IDLE: begin
                if (in_valid) begin
                    link_data_d = link;
                    if (misaligned) begin
                        misalign_d = 1'b1;
                    end else begin
                        link_valid_d = is_link;
                        if (taken) begin
                            redirect_pc_d = target;
                            state_d       = BJU_HOLD;
                        end
                    end
                end
            end
            BJU_HOLD: begin
                // redirect_pc_q is only loaded in IDLE, so it is stable here.
                if (redirect_ready) begin
                    if (FLUSH_CYCLES == 0) begin
                        state_d = BJU_IDLE;
                    end else begin
                        state_d = BJU_SQUASH;
                        cnt_d   = CNT_W'(FLUSH_CYCLES);
                    end
                end
            end
            BJU_SQUASH: begin
                // Counter holds the number of flush cycles still to show,
                // including the current one.
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = BJU_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = BJU_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BJU_IDLE;
            cnt_q         <= '0;
            redirect_pc_q <= '0;
            link_data_q   <= '0;
            link_valid_q  <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            redirect_pc_q <= redirect_pc_d;
            link_data_q   <= link_data_d;
            link_valid_q  <= link_valid_d;
            misalign_q    <= misalign_d;
        end
    end

    // Pure decodes of the state register: no path from redirect_ready.
    assign in_ready       = (state_q == BJU_IDLE);
    assign redirect_valid = (state_q == BJU_HOLD);
    assign flush          = (state_q == BJU_SQUASH);
    assign redirect_pc    = redirect_pc_q;
    assign link_valid     = link_valid_q;
    assign link_data      = link_data_q;
    assign misalign_exc   = misalign_q;

endmodule

// File: tb/tb_exe_stage_bju.sv
module tb_exe_stage_bju;
    import exe_stage_bju_pkg::*;

    localparam int AW    = 64;
    localparam int FLUSH = 2;

    localparam logic [7:0] M_BEQ  = 8'(1 << BJ_BEQ);
    localparam logic [7:0] M_BNE  = 8'(1 << BJ_BNE);
    localparam logic [7:0] M_BLT  = 8'(1 << BJ_BLT);
    localparam logic [7:0] M_BGE  = 8'(1 << BJ_BGE);
    localparam logic [7:0] M_BLTU = 8'(1 << BJ_BLTU);
    localparam logic [7:0] M_JALR = 8'(1 << BJ_JALR);
    localparam logic [7:0] M_JAL  = 8'(1 << BJ_JAL);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [AW-1:0] pc, imm, rs1;
    logic [7:0]    bj_info, bj_data;
    logic          redirect_ready;

    logic          in_ready, redirect_valid, flush, link_valid, misalign_exc;
    logic [AW-1:0] redirect_pc, link_data;
    logic          in_ready_0, redirect_valid_0, flush_0, link_valid_0, misalign_exc_0;
    logic [AW-1:0] redirect_pc_0, link_data_0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    exe_stage_bju #(.ADDR_W(AW), .FLUSH_CYCLES(FLUSH), .CNT_W(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .pc(pc), .imm(imm), .rs1(rs1), .bj_info(bj_info), .bj_data(bj_data),
        .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
        .redirect_pc(redirect_pc), .flush(flush), .link_valid(link_valid),
        .link_data(link_data), .misalign_exc(misalign_exc)
    );

    // Same stimulus, no flush cycles: must return to IDLE right after the handshake.
    exe_stage_bju #(.ADDR_W(AW), .FLUSH_CYCLES(0), .CNT_W(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_0),
        .pc(pc), .imm(imm), .rs1(rs1), .bj_info(bj_info), .bj_data(bj_data),
        .redirect_valid(redirect_valid_0), .redirect_ready(redirect_ready),
        .redirect_pc(redirect_pc_0), .flush(flush_0), .link_valid(link_valid_0),
        .link_data(link_data_0), .misalign_exc(misalign_exc_0)
    );

    typedef struct {
        logic [AW-1:0] pc;
        logic [AW-1:0] imm;
        logic [AW-1:0] rs1;
        logic [7:0]    info;
        logic [7:0]    data;
        int            stall;
        bit            redir;
        logic [AW-1:0] tgt;
        bit            lv;
        logic [AW-1:0] lnk;
        bit            mis;
    } vec_t;

    task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Reference: resolve a branch from the architectural rules.
    function automatic vec_t model(input logic [AW-1:0] p, input logic [AW-1:0] im,
                                   input logic [AW-1:0] r1, input logic [7:0] info,
                                   input logic [7:0] data, input int stall);
        vec_t v;
        bit taken;
        longint unsigned dest;
        taken = 1'b0;
        for (int b = 0; b < 8; b++)
            if (info[b] && data[b]) taken = 1'b1;
        if (info[BJ_JALR]) begin
            dest = longint'(r1) + longint'(im);
            dest = dest - (dest % 2);
        end else begin
            dest = longint'(p) + longint'(im);
        end
        v.pc = p; v.imm = im; v.rs1 = r1; v.info = info; v.data = data; v.stall = stall;
        v.tgt   = dest;
        v.mis   = taken && (dest % 4 != 0);
        v.redir = taken && !v.mis;
        v.lv    = (info[BJ_JAL] || info[BJ_JALR]) && !v.mis;
        v.lnk   = p + 64'd4;
        return v;
    endfunction

    function automatic vec_t mk(input logic [AW-1:0] p, input logic [AW-1:0] im,
                                input logic [AW-1:0] r1, input logic [7:0] info,
                                input logic [7:0] data, input int stall, input bit redir,
                                input logic [AW-1:0] tgt, input bit lv,
                                input logic [AW-1:0] lnk, input bit mis);
        vec_t v;
        v.pc = p; v.imm = im; v.rs1 = r1; v.info = info; v.data = data; v.stall = stall;
        v.redir = redir; v.tgt = tgt; v.lv = lv; v.lnk = lnk; v.mis = mis;
        return v;
    endfunction

    // Starts and ends on a falling edge with both units idle.
    task automatic run_txn(input vec_t v, input string tag);
        logic [AW-1:0] held_pc;
        chk1({tag, " in_ready before accept"}, in_ready, 1'b1);
        pc = v.pc; imm = v.imm; rs1 = v.rs1; bj_info = v.info; bj_data = v.data;
        in_valid = 1'b1;
        redirect_ready = (v.stall == 0);
        @(negedge clk);
        in_valid = 1'b0;
        chk1({tag, " link_valid"}, link_valid, v.lv);
        chk1({tag, " misalign_exc"}, misalign_exc, v.mis);
        chk1({tag, " redirect_valid"}, redirect_valid, v.redir);
        chk1({tag, " redirect_valid (no flush)"}, redirect_valid_0, v.redir);
        if (v.lv) chk({tag, " link_data"}, link_data, v.lnk);
        if (v.redir) chk({tag, " redirect_pc"}, redirect_pc, v.tgt);
        held_pc = redirect_pc;
        if (!v.redir) begin
            chk1({tag, " in_ready after"}, in_ready, 1'b1);
            chk1({tag, " flush idle"}, flush, 1'b0);
        end else begin
            for (int i = 0; i <= v.stall; i++) begin
                if (i > 0) begin
                    chk1({tag, " redirect_valid hold"}, redirect_valid, 1'b1);
                    chk({tag, " redirect_pc stable"}, redirect_pc, held_pc);
                    chk1({tag, " in_ready hold"}, in_ready, 1'b0);
                    chk1({tag, " link_valid single pulse"}, link_valid, 1'b0);
                end
                redirect_ready = (i == v.stall);
                @(negedge clk);
            end
            redirect_ready = 1'b0;
            for (int i = 0; i < FLUSH; i++) begin
                chk1({tag, " flush"}, flush, 1'b1);
                chk1({tag, " redirect_valid in squash"}, redirect_valid, 1'b0);
                chk1({tag, " in_ready in squash"}, in_ready, 1'b0);
                chk1({tag, " no-flush unit flush"}, flush_0, 1'b0);
                chk1({tag, " no-flush unit idle"}, in_ready_0, 1'b1);
                @(negedge clk);
            end
            chk1({tag, " flush done"}, flush, 1'b0);
            chk1({tag, " in_ready back"}, in_ready, 1'b1);
        end
        $display("txn %s pc=0x%0h info=0x%0h data=0x%0h stall=%0d redir=%0b tgt=0x%0h lv=%0b mis=%0b",
                 tag, v.pc, v.info, v.data, v.stall, v.redir, v.tgt, v.lv, v.mis);
    endtask

    vec_t vecs[14];

    initial begin
        vecs[0]  = mk(64'h8000_0000, 64'h10, 64'h0, M_BEQ, M_BEQ, 0, 1, 64'h8000_0010, 0, 64'h8000_0004, 0);
        vecs[1]  = mk(64'h8000_0020, 64'h40, 64'h0, M_BNE, 8'h00, 0, 0, 64'h0, 0, 64'h0, 0);
        vecs[2]  = mk(64'h8000_0024, 64'h40, 64'h0, M_BNE, 8'h00, 0, 0, 64'h0, 0, 64'h0, 0);
        vecs[3]  = mk(64'h8000_0028, 64'h8, 64'h0, 8'h00, 8'hFF, 0, 0, 64'h0, 0, 64'h0, 0);
        vecs[4]  = mk(64'h8000_0100, 64'h1, 64'h8000_1003, M_JALR, M_JALR, 3, 1, 64'h8000_1004, 1, 64'h8000_0104, 0);
        vecs[5]  = mk(64'h8000_0000, 64'h6, 64'h0, M_JAL, M_JAL, 0, 0, 64'h0, 0, 64'h0, 1);
        vecs[6]  = mk(64'hFFFF_FFFF_FFFF_FFFC, 64'h8, 64'h0, M_JAL, M_JAL, 1, 1, 64'h4, 1, 64'h0, 0);
        vecs[7]  = mk(64'h2000, 64'h5, 64'h1000, M_JALR, M_JALR, 0, 1, 64'h1004, 1, 64'h2004, 0);
        vecs[8]  = mk(64'h2000, 64'h2, 64'h1001, M_JALR, M_JALR, 0, 0, 64'h0, 0, 64'h0, 1);
        vecs[9]  = mk(64'h1000, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, M_BLTU, M_BLTU, 2, 1, 64'hFF8, 0, 64'h0, 0);
        vecs[10] = mk(64'h400, 64'h20, 64'h0, M_BEQ | M_BNE, M_BNE, 0, 1, 64'h420, 0, 64'h0, 0);
        vecs[11] = mk(64'h500, 64'h20, 64'h0, M_BGE, M_BLT, 0, 0, 64'h0, 0, 64'h0, 0);
        vecs[12] = mk(64'h100, 64'h2, 64'h0, M_BNE, M_BNE, 0, 0, 64'h0, 0, 64'h0, 1);
        vecs[13] = mk(64'h3000, 64'h40, 64'h0, M_JAL, 8'h00, 0, 0, 64'h0, 1, 64'h3004, 0);

        rst_n = 1'b0; in_valid = 1'b0; pc = '0; imm = '0; rs1 = '0;
        bj_info = '0; bj_data = '0; redirect_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        chk1("reset in_ready", in_ready, 1'b1);
        chk1("reset redirect_valid", redirect_valid, 1'b0);
        chk1("reset flush", flush, 1'b0);
        chk1("reset link_valid", link_valid, 1'b0);
        chk1("reset misalign_exc", misalign_exc, 1'b0);
        chk("reset redirect_pc", redirect_pc, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Asynchronous reset while a redirect is pending.
        pc = 64'h8000_0000; imm = 64'h10; bj_info = M_BEQ; bj_data = M_BEQ;
        in_valid = 1'b1; redirect_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk1("midhold redirect_valid", redirect_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk1("async reset redirect_valid", redirect_valid, 1'b0);
        chk1("async reset flush", flush, 1'b0);
        chk("async reset redirect_pc", redirect_pc, 64'h0);
        chk1("async reset in_ready", in_ready, 1'b1);
        chk1("async reset no-flush unit redirect_valid", redirect_valid_0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk1("post reset in_ready", in_ready, 1'b1);
        chk1("post reset redirect_valid", redirect_valid, 1'b0);
        chk1("post reset flush", flush, 1'b0);
        $display("txn reset-mid-hold done");

        // Randomized transactions against the reference model.
        for (int n = 0; n < 60; n++) begin
            logic [7:0]    info, data;
            logic [AW-1:0] p, im, r1;
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 8)       info = 8'(1 << sel);
            else if (sel == 8) info = 8'h00;
            else               info = 8'($urandom);
            data = ($urandom_range(0, 1) == 1) ? info : 8'($urandom);
            p  = {$urandom, $urandom} & ~64'h3;
            im = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) im = im & ~64'h3;
            r1 = {$urandom, $urandom};
            run_txn(model(p, im, r1, info, data, $urandom_range(0, 3)), $sformatf("rnd%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exe_stage_bju.md
Name: exe_stage_bju

Overview:
Branch/jump resolution unit in the execute stage, downstream of the ALU. It takes the ALU condition vector (`BJ_BUS`), the decoded branch type and the operands, and decides whether control flow changes. On a taken branch or jump it issues a redirect to fetch under a valid/ready handshake, then holds a flush to the front-end pipeline registers. It also produces the link value (pc+4) for JAL/JALR writeback.

Parameters:
ADDR_W, 64, width of PC, immediate, rs1 and target.
FLUSH_CYCLES, 2, number of cycles flush is held after the redirect handshake; 0 is legal.
CNT_W, 2, flush counter width; must satisfy 2^CNT_W > FLUSH_CYCLES.

Ports:
clk  in  1  clock
rst_n  in  1  reset; one clock, reset is asynchronous and active-low
in_valid  in  1  execute-stage instruction valid
in_ready  out  1  unit can accept an instruction (high only in IDLE)
pc  in  ADDR_W  PC of the instruction
imm  in  ADDR_W  sign-extended immediate
rs1  in  ADDR_W  rs1 value (JALR base)
bj_info  in  `BJ_BUS`  one-hot branch type from decode; all-zero means not a branch/jump
bj_data  in  `BJ_BUS`  per-type condition bits from the ALU
redirect_valid  out  1  redirect request to IF
redirect_ready  in  1  IF accepts the redirect
redirect_pc  out  ADDR_W  target PC
flush  out  1  squash IF/ID and ID/EXE registers
link_valid  out  1  one-cycle pulse: link_data is to be written to rd
link_data  out  ADDR_W  pc+4
misalign_exc  out  1  one-cycle pulse: the taken target is not 4-byte aligned

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counter=0. All outputs 0 except in_ready=1. Any pending redirect or flush is dropped.
- Accept: in_valid & in_ready. Combinational at accept time:
  - taken = |(bj_info & bj_data)
  - is_jalr = bj_info[`BJ_JALR`]
  - target = is_jalr ? ((rs1+imm) & ~1) : (pc+imm), modulo 2^ADDR_W (wrap-around allowed)
  - link = pc+4, modulo 2^ADDR_W
- Registered results appear on the cycle after accept (1-cycle latency):
  - link_valid = 1 for JAL/JALR, unless misaligned.
  - misalign_exc = taken & (target[1:0] != 0). When set: no redirect, no link, state stays IDLE.
  - taken & aligned: redirect_pc = target, redirect_valid = 1, state moves to HOLD.
  - Not taken, or bj_info = 0: no outputs asserted, state stays IDLE.
- Multi-hot bj_info is excluded by decode. If it occurs anyway, the OR rule above still defines the result.
- States:
  - IDLE: in_ready=1.
  - HOLD: redirect_valid=1. redirect_pc stays stable until redirect_ready is sampled high. On the handshake, go to SQUASH with counter=FLUSH_CYCLES; if FLUSH_CYCLES=0, go straight to IDLE.
  - SQUASH: flush=1 and redirect_valid=0. The counter decrements each cycle; move to IDLE in the cycle it reaches 1.
- in_ready=0 in HOLD and SQUASH, so in_valid is ignored there and no second redirect can overlap.
- redirect_ready high in the first HOLD cycle completes the handshake in that cycle: redirect_valid is high for exactly 1 cycle.
- redirect_valid must never drop before the handshake.
- All state and outputs are registered; no combinational path from redirect_ready to in_ready.

Decomposition:
- Shared defines file: `BJ_BUS` and the `BJ_*` bit indices (BEQ, BNE, BLT, BGE, BLTU, BGEU, JALR, JAL), plus state encodings BJU_IDLE/BJU_HOLD/BJU_SQUASH.
- One sub-module is natural: exe_stage_bju_target, combinational adder/mux for target and link.
- The FSM and counter stay in the top level.

Test Plan:
- BEQ taken, aligned: pc=0x80000000, imm=0x10, bj_info=BEQ, bj_data[BEQ]=1, redirect_ready=1. Required: redirect_valid for 1 cycle with redirect_pc=0x80000010, then flush for 2 cycles, then in_ready=1.
- Branch not taken: bj_info=BNE, bj_data=0. Required: no redirect, no flush, in_ready stays 1, and back-to-back accepts on consecutive cycles succeed.
- JALR with ready stalled: rs1=0x80001003, imm=1, redirect_ready=0 for 3 cycles. Required: link_valid pulse with link_data=pc+4, redirect_pc=0x80001004 held stable for 4 cycles, in_ready=0 throughout, then 2 flush cycles.
- Misaligned JAL: pc=0x80000000, imm=0x6. Required: misalign_exc pulse, no link_valid, no redirect_valid, state stays IDLE.
- Wrap-around: pc=0xFFFFFFFF_FFFFFFFC, JAL, imm=0x8. Required: redirect_pc=0x4, link_data=0x0.
- Reset mid-HOLD: drop rst_n while redirect_valid=1. Required: all outputs 0 immediately (asynchronously) and in_ready=1 after release. Repeat the first scenario with FLUSH_CYCLES=0: no flush cycle, IDLE immediately after the handshake.
